// File: rtl/ifetch_pkg.sv
// Shared types and AXI constants for the instruction-fetch read master.
package ifetch_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 8;
  localparam int unsigned AXI_SIZE_BITS = 3;
  localparam int unsigned AXI_DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    RESP
  } fsm_e;

  localparam logic [AXI_SIZE_BITS-1:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0]               ARBURST_INCR = 2'b01;
  localparam logic [1:0]               RESP_OKAY    = 2'b00;

  // Read-address channel payload
  typedef struct packed {
    logic [AXI_ID_BITS-1:0]   id;
    logic [AXI_ADDR_BITS-1:0] addr;
    logic [AXI_LEN_BITS-1:0]  len;
    logic [AXI_SIZE_BITS-1:0] size;
    logic [1:0]               burst;
  } ar_chan_t;

endpackage

// File: rtl/fetch_line_buf.sv
// One-line fetch buffer: word storage plus tag, line-valid and deferred-flush state.
module fetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [$clog2(LINE_BEATS)-1:0]           wr_idx,
  input  logic [AXI_DATA_BITS-1:0]                wr_data,
  input  logic [$clog2(LINE_BEATS)-1:0]           rd_idx,
  output logic [AXI_DATA_BITS-1:0]                rd_data_c,
  input  logic                                    tag_we,
  input  logic [31-($clog2(LINE_BEATS)+2):0]      tag_wdata,
  output logic [31-($clog2(LINE_BEATS)+2):0]      tag,
  input  logic                                    valid_clr,
  input  logic                                    valid_set,
  output logic                                    buf_valid,
  input  logic                                    flush_pend_set,
  input  logic                                    flush_pend_clr,
  output logic                                    flush_pend
);

  logic [AXI_DATA_BITS-1:0] mem [LINE_BEATS];

  assign rd_data_c = mem[rd_idx];

  // Word storage, written one beat at a time during a refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINE_BEATS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Invalidation always wins over a concurrent set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag        <= '0;
      buf_valid  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (tag_we) tag <= tag_wdata;
      if (valid_clr)      buf_valid <= 1'b0;
      else if (valid_set) buf_valid <= 1'b1;
      if (flush_pend_clr)      flush_pend <= 1'b0;
      else if (flush_pend_set) flush_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_axi_read_master.sv
// AXI4 read-only master for instruction fetch: serves hits from a one-line buffer,
// refills the line with a single aligned INCR burst on a miss.
module ifetch_axi_read_master
  import ifetch_pkg::*;
#(
  parameter int unsigned            LINE_BEATS = 4,
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID  = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic [AXI_ID_BITS-1:0]   ARID,
  output logic [AXI_ADDR_BITS-1:0] ARADDR,
  output logic [AXI_LEN_BITS-1:0]  ARLEN,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]               ARBURST,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [AXI_ID_BITS-1:0]   RID,
  input  logic [AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RLAST,
  input  logic                     RVALID,
  output logic                     RREADY
);

  localparam int unsigned WORD_BITS = $clog2(LINE_BEATS);
  localparam int unsigned OFS       = WORD_BITS + 2;
  localparam int unsigned TAG_BITS  = 32 - OFS;
  localparam int unsigned CNT_BITS  = WORD_BITS + 1;
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(LINE_BEATS - 1);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(LINE_BEATS);

  fsm_e                  state_q, state_d;
  logic [WORD_BITS-1:0]  word_q, word_d;
  logic [CNT_BITS-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic                  arvalid_d, rready_d, req_ready_d;
  logic                  rsp_valid_d, rsp_err_d;
  logic [31:0]           rsp_data_d;

  logic                  wr_en, tag_we, valid_clr, valid_set;
  logic                  flush_pend_set, flush_pend_clr, flush_pend;
  logic [WORD_BITS-1:0]  rd_idx;
  logic [31:0]           rd_data_c;
  logic [TAG_BITS-1:0]   tag;
  logic                  buf_valid;
  logic                  in_range, beat_err;

  logic [TAG_BITS-1:0]   req_tag;
  logic [WORD_BITS-1:0]  req_word;
  logic                  unused_in;

  assign req_tag   = req_addr[31:OFS];
  assign req_word  = req_addr[OFS-1:2];
  assign unused_in = ^{RID, req_addr[1:0]};

  // AR payload is constant apart from the registered line tag, so it is stable while ARVALID waits
  ar_chan_t ar;
  assign ar = '{id:    MASTER_ID,
                addr:  {tag, {OFS{1'b0}}},
                len:   AXI_LEN_BITS'(LINE_BEATS - 1),
                size:  ARSIZE_WORD,
                burst: ARBURST_INCR};

  assign ARID    = ar.id;
  assign ARADDR  = ar.addr;
  assign ARLEN   = ar.len;
  assign ARSIZE  = ar.size;
  assign ARBURST = ar.burst;

  fetch_line_buf #(
    .LINE_BEATS (LINE_BEATS)
  ) u_buf (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_idx         (beat_cnt_q[WORD_BITS-1:0]),
    .wr_data        (RDATA),
    .rd_idx         (rd_idx),
    .rd_data_c      (rd_data_c),
    .tag_we         (tag_we),
    .tag_wdata      (req_tag),
    .tag            (tag),
    .valid_clr      (valid_clr),
    .valid_set      (valid_set),
    .buf_valid      (buf_valid),
    .flush_pend_set (flush_pend_set),
    .flush_pend_clr (flush_pend_clr),
    .flush_pend     (flush_pend)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state, buffer control and next output values
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    beat_cnt_d     = beat_cnt_q;
    err_d          = err_q;
    arvalid_d      = 1'b0;
    rready_d       = 1'b0;
    req_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_data_d     = rsp_data;
    wr_en          = 1'b0;
    tag_we         = 1'b0;
    valid_clr      = 1'b0;
    valid_set      = 1'b0;
    flush_pend_set = 1'b0;
    flush_pend_clr = 1'b0;
    rd_idx         = word_q;
    in_range       = (beat_cnt_q != CNT_SAT);
    beat_err       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        rd_idx      = req_word;
        valid_clr   = flush;
        if (req_valid && req_ready) begin
          if (buf_valid && (tag == req_tag) && !flush) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data_c;
          end else begin
            state_d     = AR;
            word_d      = req_word;
            tag_we      = 1'b1;
            valid_clr   = 1'b1;
            arvalid_d   = 1'b1;
            req_ready_d = 1'b0;
          end
        end
      end

      AR: begin
        flush_pend_set = flush;
        if (ARVALID && ARREADY) begin
          state_d  = R;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      R: begin
        flush_pend_set = flush;
        rready_d       = 1'b1;
        if (RVALID && RREADY) begin
          wr_en = in_range;
          if (in_range) beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
          // Short burst, or the final slot passed without RLAST
          beat_err = (RRESP != RESP_OKAY) ||
                     (RLAST ? (beat_cnt_q != LAST_IDX) : (beat_cnt_q == LAST_IDX));
          err_d = err_q | beat_err;
          if (RLAST) begin
            state_d     = RESP;
            rready_d    = 1'b0;
            valid_set   = !err_d && !flush_pend && !flush;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            rsp_data_d  = (in_range && (beat_cnt_q[WORD_BITS-1:0] == word_q)) ? RDATA : rd_data_c;
          end
        end
      end

      RESP: begin
        beat_cnt_d     = '0;
        err_d          = 1'b0;
        flush_pend_clr = 1'b1;
        valid_clr      = flush;
        state_d        = IDLE;
        req_ready_d    = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ARVALID   <= arvalid_d;
      RREADY    <= rready_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ifetch_axi_read_master.sv
// Bench for ifetch_axi_read_master: directed vector table, back-to-back hits, reset
// mid-burst, and randomized fetches checked against a line-level buffer model.
module tb_ifetch_axi_read_master;
  import ifetch_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     req_valid = 1'b0;
  logic [31:0]              req_addr = '0;
  logic                     req_ready;
  logic                     flush = 1'b0;
  logic                     rsp_valid;
  logic [31:0]              rsp_data;
  logic                     rsp_err;
  logic [AXI_ID_BITS-1:0]   ARID;
  logic [AXI_ADDR_BITS-1:0] ARADDR;
  logic [AXI_LEN_BITS-1:0]  ARLEN;
  logic [AXI_SIZE_BITS-1:0] ARSIZE;
  logic [1:0]               ARBURST;
  logic                     ARVALID;
  logic                     ARREADY = 1'b0;
  logic [AXI_ID_BITS-1:0]   RID = '0;
  logic [AXI_DATA_BITS-1:0] RDATA = '0;
  logic [1:0]               RRESP = '0;
  logic                     RLAST = 1'b0;
  logic                     RVALID = 1'b0;
  logic                     RREADY;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one buffered line (byte base address) and its validity
  logic        m_valid = 1'b0;
  logic [31:0] m_line  = '0;

  always #5 clk = ~clk;

  ifetch_axi_read_master #(.LINE_BEATS(4), .MASTER_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    int          gap;
    int          err_beat;
    int          last_beat;
    logic        flush_req;
    logic        flush_ar;
    int          flush_beat;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One fetch from an IDLE-ready negedge; acts as the slave; returns at a negedge ready for the next one
  task automatic do_fetch(input logic [31:0] a, input int ar_delay, input int gap,
                          input int err_beat, input int last_beat, input logic flush_req,
                          input logic flush_ar, input int flush_beat, input logic exp_hit,
                          input logic [31:0] exp_data, input logic exp_err, input string nm);
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    check({nm, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    flush     = flush_req;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    req_addr  = $urandom;
    if (exp_hit) begin
      check({nm, "/hit_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "/hit_rsp_data"}, rsp_data, exp_data);
      check({nm, "/hit_rsp_err"}, 32'(rsp_err), 32'd0);
      check({nm, "/hit_no_ar"}, 32'(ARVALID), 32'd0);
      return;
    end
    check({nm, "/arvalid"}, 32'(ARVALID), 32'd1);
    check({nm, "/araddr"}, ARADDR, line);
    check({nm, "/ar_const"}, {ARID, ARLEN, ARSIZE, ARBURST, 15'd0},
          {4'd0, 8'd3, 3'd2, 2'd1, 15'd0});
    check({nm, "/miss_no_rsp"}, 32'(rsp_valid), 32'd0);
    flush = flush_ar;
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      flush = 1'b0;
      check({nm, "/ar_hold"}, 32'(ARVALID && (ARADDR == line)), 32'd1);
    end
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    flush   = 1'b0;
    check({nm, "/ar_done"}, 32'(ARVALID), 32'd0);
    check({nm, "/rready"}, 32'(RREADY), 32'd1);
    for (int b = 0; b <= last_beat; b++) begin
      repeat (gap) @(negedge clk);
      RVALID = 1'b1;
      RDATA  = slave_word(line + (32'(b) << 2));
      RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (b == last_beat);
      flush  = (b == flush_beat);
      @(negedge clk);
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
      flush  = 1'b0;
      if (b < last_beat) check({nm, "/early_rsp"}, 32'(rsp_valid), 32'd0);
    end
    check({nm, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (!exp_err) check({nm, "/rsp_data"}, rsp_data, exp_data);
    check({nm, "/rsp_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check({nm, "/back_idle"}, {31'd0, req_ready}, 32'd1);
    check({nm, "/rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  // Model update after a fetch: a clean, unflushed refill leaves its line buffered
  task automatic model_after(input logic [31:0] a, input logic hit, input logic err,
                             input logic flush_ar, input int flush_beat, input int last_beat);
    if (!hit) begin
      m_line  = {a[31:4], 4'h0};
      m_valid = !err && !flush_ar && !(flush_beat <= last_beat);
    end
  endtask

  task automatic back_to_back(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = base + 32'(k * 4);
      @(negedge clk);
      check($sformatf("b2b%0d/rsp_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("b2b%0d/rsp_data", k), rsp_data, slave_word(base + 32'(k * 4)));
      check($sformatf("b2b%0d/no_ar", k), 32'(ARVALID), 32'd0);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr    ard gap err last fr   fa   fb  hit   data      err
    vecs[0]  = '{32'h00, 2, 0, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hA2, 1'b0};
    vecs[1]  = '{32'h0C, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b1, 32'hA3, 1'b0};
    vecs[2]  = '{32'h10, 1, 3, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hA4, 1'b0};
    vecs[3]  = '{32'h1C, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b1, 32'hA7, 1'b0};
    vecs[4]  = '{32'h00, 0, 0,  1, 3, 1'b0, 1'b0, 99, 1'b0, 32'hA0, 1'b1};
    vecs[5]  = '{32'h00, 1, 0, 99, 1, 1'b0, 1'b0, 99, 1'b0, 32'hA0, 1'b1};
    vecs[6]  = '{32'h04, 0, 1, 99, 3, 1'b0, 1'b0,  2, 1'b0, 32'hA1, 1'b0};
    vecs[7]  = '{32'h04, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hA1, 1'b0};
    vecs[8]  = '{32'h08, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b1, 32'hA2, 1'b0};
    vecs[9]  = '{32'h08, 0, 0, 99, 3, 1'b1, 1'b0, 99, 1'b0, 32'hA2, 1'b0};
    vecs[10] = '{32'h30, 2, 0, 99, 3, 1'b0, 1'b1, 99, 1'b0, 32'hAC, 1'b0};
    vecs[11] = '{32'h34, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hAD, 1'b0};
    vecs[12] = '{32'h36, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b1, 32'hAD, 1'b0};
    vecs[13] = '{32'h40, 0, 1, 99, 5, 1'b0, 1'b0, 99, 1'b0, 32'hB0, 1'b1};
    vecs[14] = '{32'h40, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hB0, 1'b0};
    vecs[0].addr = 32'h08;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset/arvalid", 32'(ARVALID), 32'd0);
    check("reset/rready", 32'(RREADY), 32'd0);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_data", rsp_data, 32'd0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      do_fetch(vecs[i].addr, vecs[i].ar_delay, vecs[i].gap, vecs[i].err_beat,
               vecs[i].last_beat, vecs[i].flush_req, vecs[i].flush_ar, vecs[i].flush_beat,
               vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
      model_after(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_err, vecs[i].flush_ar,
                  vecs[i].flush_beat, vecs[i].last_beat);
      if (i == 0) back_to_back(32'h0);
    end

    // Randomized fetches against the line model
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int ard, gp, eb, lb, fb, sel;
      logic fr, fa, hit, err;
      a   = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      ard = $urandom_range(0, 3);
      gp  = $urandom_range(0, 2);
      eb  = $urandom_range(0, 15);
      sel = $urandom_range(0, 7);
      lb  = (sel == 0) ? 1 : (sel == 1) ? 5 : 3;
      fr  = ($urandom_range(0, 7) == 0);
      fa  = ($urandom_range(0, 7) == 0);
      fb  = $urandom_range(0, 15);
      hit = m_valid && (m_line == {a[31:4], 4'h0}) && !fr;
      err = !hit && ((eb <= lb) || (lb != 3));
      do_fetch(a, ard, gp, eb, lb, fr, fa, fb, hit, slave_word(a), err,
               $sformatf("rnd%0d", t));
      model_after(a, hit, err, fa, fb, lb);
    end

    // Make a line valid, then reset in the middle of the next refill's AR phase
    do_fetch(32'h50, 0, 0, 99, 3, 1'b0, 1'b0, 99,
             m_valid && (m_line == 32'h50), 32'hB4, 1'b0, "pre_rst");
    model_after(32'h50, m_valid && (m_line == 32'h50), 1'b0, 1'b0, 99, 3);
    req_valid = 1'b1;
    req_addr  = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid/arvalid_before", 32'(ARVALID), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid/arvalid", 32'(ARVALID), 32'd0);
    check("rst_mid/rready", 32'(RREADY), 32'd0);
    check("rst_mid/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid/req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    check("post_rst/arvalid", 32'(ARVALID), 32'd0);
    do_fetch(32'h54, 0, 0, 99, 3, 1'b0, 1'b0, 99, 1'b0, 32'hB5, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
